// File: rtl/sb_shadow.sv
// sb_shadow: switchbox for one routing-grid intersection.
//
// Each output track on each side has its own 4:1 source mux. The mux can select
// one of the three other sides, or it can be switched off (drives 0). The routing
// comes from an "active" configuration register.
//
// A new configuration is shifted serially into a "shadow" register through the
// fabric config chain. The routing keeps running on the active copy meanwhile.
// A commit pulse copies shadow to active in one cycle, but only when exactly
// CFG_BITS bits have been shifted since the last commit or since entering LOAD.
//
// Optional feature (macro SB_OUTPUT_REG_EN):
//   - Each output field gains a "reg" bit.
//   - When reg=1, that output is taken from a pipeline flop instead of the
//     combinational mux.
//
// Field layout, track i, output direction d (N=0, E=1, S=2, W=3):
//   base = (i*4+d)*(2+R)
//   sel  = [base+1:base]
//   reg  = [base+2]      (only when R=1)
module sb_shadow #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             config_en,
  input  logic             config_data_in,
  output logic             config_data_out,
  input  logic             commit,
  output logic             cfg_busy,
  output logic             cfg_valid,
  output logic             cfg_error,
  input  logic [WIDTH-1:0] north_in,
  input  logic [WIDTH-1:0] east_in,
  input  logic [WIDTH-1:0] south_in,
  input  logic [WIDTH-1:0] west_in,
  output logic [WIDTH-1:0] north_out,
  output logic [WIDTH-1:0] east_out,
  output logic [WIDTH-1:0] south_out,
  output logic [WIDTH-1:0] west_out
);

`ifdef SB_OUTPUT_REG_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int FW       = 2 + R;
  localparam int CFG_BITS = WIDTH * 4 * FW;
  localparam int CW       = $clog2(CFG_BITS + 1);

  typedef enum logic {
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t                state_q, state_d;
  logic [CFG_BITS-1:0]   shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   active_q, active_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  shift_req;

  assign shift_req = en & config_en;

  // Next state for the RUN/LOAD mode machine.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (config_en)  state_d = ST_LOAD;
      ST_LOAD: if (!config_en) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath: shift the shadow chain, count bits, and evaluate commits.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    error_d  = error_q;
    if (state_q == ST_RUN) begin
      // Entering LOAD starts a fresh bit count. A commit in RUN is ignored.
      if (config_en) cnt_d = '0;
      if (shift_req) shadow_d = {shadow_q[CFG_BITS-2:0], config_data_in};
    end else if (commit) begin
      // The commit is judged on the pre-shift count. Any shift requested in
      // the same cycle is dropped.
      if (cnt_q == CW'(CFG_BITS)) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        error_d  = 1'b0;
      end else begin
        error_d  = 1'b1;
      end
      cnt_d = '0;
    end else if (shift_req) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], config_data_in};
      if (cnt_q != CW'(CFG_BITS)) cnt_d = cnt_q + CW'(1);
    end
  end

  // State and configuration registers. Reset to all 1s leaves every output off.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_RUN;
      shadow_q <= '1;
      active_q <= '1;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign config_data_out = shadow_q[CFG_BITS-1];
  assign cfg_busy        = (state_q == ST_LOAD);
  assign cfg_valid       = valid_q;
  assign cfg_error       = error_q;

  // Routing fabric. Inputs and outputs are packed by direction index.
  logic [3:0][WIDTH-1:0] dir_in;
  logic [3:0][WIDTH-1:0] dir_out;

  assign dir_in[0] = north_in;
  assign dir_in[1] = east_in;
  assign dir_in[2] = south_in;
  assign dir_in[3] = west_in;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    for (genvar i = 0; i < WIDTH; i++) begin : g_trk
      localparam int BASE = (i * 4 + d) * FW;
      logic [1:0] sel;
      logic [1:0] src;
      logic       route;

      // sel 00/01/10 picks direction (d+1)/(d+2)/(d+3) mod 4.
      // The 2-bit sum wraps modulo 4, which gives the mod 4 for free.
      assign sel   = active_q[BASE+1:BASE];
      assign src   = 2'(d + 1) + sel;
      assign route = (sel == 2'b11) ? 1'b0 : dir_in[src][i];

`ifdef SB_OUTPUT_REG_EN
      logic pipe_q;

      // Pipeline flop: captures the mux result on every edge, whatever the
      // config mode.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) pipe_q <= 1'b0;
        else       pipe_q <= route;
      end

      assign dir_out[d][i] = active_q[BASE+2] ? pipe_q : route;
`else
      assign dir_out[d][i] = route;
`endif
    end
  end

  assign north_out = dir_out[0];
  assign east_out  = dir_out[1];
  assign south_out = dir_out[2];
  assign west_out  = dir_out[3];

endmodule

// File: tb/tb_sb_shadow.sv
// Testbench for sb_shadow (WIDTH=2). Works with or without SB_OUTPUT_REG_EN.
// A behavioural model holds the shadow and active configuration as bit arrays.
// The outputs are predicted from the field rules.
module tb_sb_shadow;
  localparam int WIDTH = 2;
`ifdef SB_OUTPUT_REG_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int FW       = 2 + R;
  localparam int CFG_BITS = WIDTH * 4 * FW;

  logic clk = 1'b0;
  logic nrst, en, config_en, config_data_in, commit;
  logic config_data_out, cfg_busy, cfg_valid, cfg_error;
  logic [WIDTH-1:0] north_in, east_in, south_in, west_in;
  logic [WIDTH-1:0] north_out, east_out, south_out, west_out;

  int n_checks = 0;
  int n_errors = 0;

  sb_shadow #(.WIDTH(WIDTH)) dut (
    .clk(clk), .nrst(nrst), .en(en), .config_en(config_en),
    .config_data_in(config_data_in), .config_data_out(config_data_out),
    .commit(commit), .cfg_busy(cfg_busy), .cfg_valid(cfg_valid),
    .cfg_error(cfg_error),
    .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
    .north_out(north_out), .east_out(east_out), .south_out(south_out),
    .west_out(west_out)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit m_shadow[CFG_BITS];
  bit m_active[CFG_BITS];
  int m_cnt;
  bit m_load, m_valid, m_error;
  bit m_reg[4][WIDTH];
  bit frame[CFG_BITS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_in(input int d, input int i);
    case (d)
      0: return north_in[i];
      1: return east_in[i];
      2: return south_in[i];
      default: return west_in[i];
    endcase
  endfunction

  // Source value selected by the active config for output d of track i.
  function automatic logic model_src(input int d, input int i);
    int base = (i * 4 + d) * FW;
    int sel  = int'(m_active[base]) + 2 * int'(m_active[base+1]);
    if (sel == 3) return 1'b0;
    return get_in((d + sel + 1) % 4, i);
  endfunction

  function automatic logic model_out(input int d, input int i);
`ifdef SB_OUTPUT_REG_EN
    if (m_active[(i * 4 + d) * FW + 2]) return m_reg[d][i];
`endif
    return model_src(d, i);
  endfunction

  function automatic logic [WIDTH-1:0] exp_dir(input int d);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = model_out(d, i);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] dut_dir(input int d);
    case (d)
      0: return north_out;
      1: return east_out;
      2: return south_out;
      default: return west_out;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CFG_BITS; k++) begin
      m_shadow[k] = 1'b1;
      m_active[k] = 1'b1;
    end
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < WIDTH; i++) m_reg[d][i] = 1'b0;
    m_cnt = 0; m_load = 0; m_valid = 0; m_error = 0;
  endtask

  task automatic model_shift();
    for (int k = CFG_BITS - 1; k > 0; k--) m_shadow[k] = m_shadow[k-1];
    m_shadow[0] = config_data_in;
  endtask

  // Advance the model by one clock edge, using the inputs as sampled at that edge.
  task automatic model_edge();
    bit nreg[4][WIDTH];
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < WIDTH; i++) nreg[d][i] = model_src(d, i);
    if (!m_load) begin
      if (config_en) begin
        m_load = 1;
        m_cnt  = 0;
      end
      if (en && config_en) model_shift();
    end else begin
      if (commit) begin
        if (m_cnt == CFG_BITS) begin
          m_active = m_shadow;
          m_valid  = 1;
          m_error  = 0;
        end else begin
          m_error = 1;
        end
        m_cnt = 0;
      end else if (en && config_en) begin
        model_shift();
        if (m_cnt < CFG_BITS) m_cnt++;
      end
      if (!config_en) m_load = 0;
    end
    m_reg = nreg;
  endtask

  task automatic check_outs(input string tag);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s out%0d", tag, d), 32'(dut_dir(d)), 32'(exp_dir(d)));
  endtask

  task automatic check_all(input string tag);
    check_outs(tag);
    check({tag, " cdo"},   32'(config_data_out), 32'(m_shadow[CFG_BITS-1]));
    check({tag, " busy"},  32'(cfg_busy),  32'(m_load));
    check({tag, " valid"}, 32'(cfg_valid), 32'(m_valid));
    check({tag, " error"}, 32'(cfg_error), 32'(m_error));
  endtask

  task automatic do_cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_ins(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] e,
                         input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] w);
    north_in = n; east_in = e; south_in = s; west_in = w;
    #1;
    check_outs("comb");
  endtask

  task automatic rand_ins();
    set_ins(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
  endtask

  // Shift the first nbits of the frame, MSB first, so a full frame lands in order.
  task automatic shift_frame(input int nbits);
    en = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      config_data_in = frame[CFG_BITS - 1 - k];
      do_cycle("shift");
    end
    en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    do_cycle("commit");
    commit = 1'b0;
  endtask

  // Directed frame: track0 N sel=01, track1 W sel=10, everything else off.
  task automatic build_frame(input bit reg_bit);
    int b;
    for (int k = 0; k < CFG_BITS; k++) frame[k] = 1'b1;
    frame[0] = 1'b1; frame[1] = 1'b0;
    b = (1 * 4 + 3) * FW;
    frame[b] = 1'b0; frame[b+1] = 1'b1;
    if (R == 1) begin
      frame[2]   = reg_bit;
      frame[b+2] = 1'b0;
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; config_en = 1'b0; config_data_in = 1'b0; commit = 1'b0;
    north_in = '1; east_in = '1; south_in = '1; west_in = '1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    nrst = 1'b1;
    do_cycle("idle");

    // Directed full frame, then commit.
    build_frame(1'b0);
    config_en = 1'b1;
    do_cycle("enter");
    shift_frame(CFG_BITS);
    do_commit();
    check("valid_after_commit", 32'(cfg_valid), 32'd1);
    set_ins('0, '0, 2'b01, '0);
    check("n0_follows_s0_hi", 32'(north_out[0]), 32'd1);
    check("w1_follows_s1_lo", 32'(west_out[1]), 32'd0);
    set_ins('1, '1, 2'b10, '1);
    check("n0_follows_s0_lo", 32'(north_out[0]), 32'd0);
    check("w1_follows_s1_hi", 32'(west_out[1]), 32'd1);

    // A short frame is rejected, and the routing is kept.
    shift_frame(5);
    do_commit();
    check("short_commit_error", 32'(cfg_error), 32'd1);
    set_ins('0, '0, 2'b01, '0);
    check("route_kept", 32'(north_out[0]), 32'd1);
    shift_frame(CFG_BITS);
    do_commit();
    check("full_commit_clears_error", 32'(cfg_error), 32'd0);

    // While in LOAD, the live route keeps tracking its input.
    for (int k = 0; k < 4; k++) begin
      set_ins('0, '0, {1'b0, k[0]}, '0);
      check("load_track", 32'(north_out[0]), 32'(k[0]));
      en = 1'b1; config_data_in = k[1];
      do_cycle("load_shift");
    end
    en = 1'b0;

`ifdef SB_OUTPUT_REG_EN
    // Registered route: the output shows 1-cycle latency.
    build_frame(1'b1);
    do_commit();   // Resets the count after the stray shifts above.
    shift_frame(CFG_BITS);
    do_commit();
    set_ins('0, '0, '0, '0);
    do_cycle("reg_lo");
    set_ins('0, '0, 2'b01, '0);
    check("reg_old_value", 32'(north_out[0]), 32'd0);
    do_cycle("reg_capture");
    check("reg_new_value", 32'(north_out[0]), 32'd1);
`endif

    config_en = 1'b0;
    do_cycle("exit");
    check("busy_low_after_exit", 32'(cfg_busy), 32'd0);

    // Reset in the middle of a LOAD.
    config_en = 1'b1;
    do_cycle("enter2");
    for (int k = 0; k < CFG_BITS; k++) frame[k] = 1'($urandom);
    shift_frame(10);
    nrst = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    #2;
    nrst = 1'b1;
    do_cycle("reenter");
    build_frame(1'b0);
    shift_frame(CFG_BITS);
    do_commit();
    check("commit_after_reset", 32'(cfg_valid), 32'd1);

    // Randomized frames, commits, mode toggles and traffic.
    for (int f = 0; f < 40; f++) begin
      int r, len;
      config_en = 1'b1; en = 1'b0;
      rand_ins();
      do_cycle("r_enter");
      r = $urandom_range(0, 3);
      case (r)
        0: len = CFG_BITS;
        1: len = CFG_BITS + $urandom_range(1, 4);
        2: len = $urandom_range(1, CFG_BITS - 1);
        default: len = CFG_BITS;
      endcase
      for (int k = 0; k < len; k++) begin
        config_data_in = 1'($urandom);
        en = (r == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rand_ins();
        do_cycle("r_shift");
      end
      commit = 1'b1; en = 1'($urandom); config_data_in = 1'($urandom);
      do_cycle("r_commit");
      commit = 1'b0; en = 1'b0;
      config_en = 1'($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 3; k++) begin
        commit = 1'($urandom); en = 1'($urandom);
        rand_ins();
        do_cycle("r_run");
      end
      commit = 1'b0; en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sb_shadow.md
# sb_shadow

Parametrised switchbox with unidirectional per-direction ports, a shadow configuration chain and atomic commit. It sits at each routing-grid intersection and is chained with the other fabric config registers. Unlike the earlier single-bus switchbox, every output of every track has its own 4:1 source mux, so one track can carry independent N→W and E→S routes. Reconfiguration happens while the active routing keeps running, and an optional per-output pipeline flop is available.

## Interface
- `WIDTH`, 32: tracks per side.
- `R`: derived, 1 if `SB_OUTPUT_REG_EN` is defined, else 0.
- `CFG_BITS`: derived, `WIDTH*4*(2+R)`.
- `clk`  in  1  clock.
- `nrst`  in  1  reset. Asynchronous, active-low.
- `en`  in  1  config shift enable; a shift occurs only while `config_en`=1.
- `config_en`  in  1  config mode; routing stays live on the active config.
- `config_data_in`  in  1  serial config input.
- `config_data_out`  out  1  serial output, equal to shadow MSB.
- `commit`  in  1  single-cycle pulse; copies shadow to active.
- `cfg_busy`  out  1  FSM is in LOAD.
- `cfg_valid`  out  1  at least one good commit has occurred since reset.
- `cfg_error`  out  1  sticky flag: a commit arrived with the wrong bit count.
- `north_in`, `east_in`, `south_in`, `west_in`  in  WIDTH  track inputs.
- `north_out`, `east_out`, `south_out`, `west_out`  out  WIDTH  track outputs.

## Operation
- Direction indices: N=0, E=1, S=2, W=3.
- Field for track i, output direction d:
  - base = `(i*4+d)*(2+R)`.
  - `sel` = bits [base+1:base].
  - `reg` = bit [base+2] (only when R=1).
- `sel` decode for output d:
  - 00 selects in[(d+1)%4].
  - 01 selects in[(d+2)%4].
  - 10 selects in[(d+3)%4].
  - 11 is off; the output drives 0. No tristates anywhere.
- Shadow register:
  - On each cycle with `en` && `config_en`: shadow <= {shadow[CFG_BITS-2:0], config_data_in}.
  - The bit counter increments and saturates at CFG_BITS.
- FSM:
  - RUN → LOAD when `config_en`=1; the counter clears on entry.
  - LOAD → RUN when `config_en`=0; shadow contents are kept.
  - `commit` is honoured only in LOAD and ignored in RUN.
- Commit in LOAD:
  - If count==CFG_BITS: active <= shadow, `cfg_valid`<=1, `cfg_error`<=0.
  - Otherwise: active is unchanged and `cfg_error`<=1.
  - The counter clears in both cases; the FSM stays in LOAD.
- `commit` together with a shift in the same cycle: the commit is evaluated on the pre-shift count and the shift is dropped.
- Reset values:
  - shadow = all 1s; active = all 1s, so every output is off.
  - counter = 0; FSM = RUN.
  - `cfg_busy`, `cfg_valid`, `cfg_error` = 0.
  - All outputs 0; `config_data_out`=1.
- Reset asserted mid-LOAD: everything returns to reset values. If `config_en` is still high after release, LOAD is re-entered on the next edge with count 0.

## Timing
- Combinational route (reg=0 or R=0): input → output in zero cycles.
- Registered route (reg=1): output = selected source sampled at the previous edge, i.e. 1-cycle latency. The flop updates every edge, independent of `en` and `config_en`.
- Commit sampled at edge k: the new routing is visible right after edge k. A registered output shows a value captured at edge k, which used the old `sel`.
- `config_data_out` follows shadow MSB and is valid one edge after each shift.
- `cfg_busy` rises one edge after `config_en` rises and falls one edge after it falls.
- Status flags update on the commit edge.

## Configuration
- `SB_OUTPUT_REG_EN` defined:
  - R=1, and each output field carries the `reg` bit.
  - Output flops reset to 0.
- `SB_OUTPUT_REG_EN` undefined:
  - R=0 and no output flops are built.
  - CFG_BITS = `WIDTH*8`, and all routes are combinational.

## Test plan
Test plan uses WIDTH=2.
- After reset, all `*_in`=2'b11 → all outputs 0, `config_data_out`=1, `cfg_valid`=0.
- Shift a full frame (24 bits with macro, 16 without) setting track0 N `sel`=01 and track1 W `sel`=10, all other fields 11; then commit → `north_out[0]` follows `south_in[0]`, `west_out[1]` follows `south_in[1]`, `cfg_valid`=1.
- Shift 5 bits, then commit → `cfg_error`=1 and routing unchanged. Then shift a full frame and commit → `cfg_error`=0.
- During LOAD, toggle `south_in[0]` → `north_out[0]` keeps tracking it combinationally with the old config, with no forced-zero gap.
- With macro: commit track0 N `sel`=01, `reg`=1; drive `south_in[0]` 0→1 at edge k → `north_out[0]` goes to 1 after edge k+1.
- Assert `nrst` after 10 of 24 shifted bits → all outputs 0 and state RUN. Keep `config_en` high, shift 24 bits and commit → the commit succeeds.
